// File: rtl/graphics_bus_arbiter.sv
// Two-requester round-robin arbiter that serialises register writes into the graphics engine.
// Optional frame lock (macro GFX_ARB_FRAME_LOCK_EN) holds granted writes until vertical blanking.
module graphics_bus_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              vblank,
  output logic              chipselect,
  output logic [ADDR_W-1:0] data_address,
  output logic [DATA_W-1:0] databus,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VB = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  logic [1:0]        state;
  logic              last_grant;
  logic              lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              win_id;
  logic              gate_open;

`ifdef GFX_ARB_FRAME_LOCK_EN
  assign gate_open = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign gate_open     = 1'b1;
`endif

  // Handshake: reqN is a valid held with stable addr/data; ackN is the one-cycle ready/commit pulse.
  // A req still high after its ack is a fresh request.
  assign win_id = req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      wr_count   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            lat_id   <= win_id;
            lat_addr <= win_id ? addr1 : addr0;
            lat_data <= win_id ? data1 : data0;
            state    <= gate_open ? WRITE : WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (gate_open) state <= WRITE;
        end
        WRITE: begin
          last_grant <= lat_id;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'h0001;
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus is forced to zero outside the strobe cycle so the engine never sees stale values.
  always_comb begin
    chipselect   = (state == WRITE);
    data_address = chipselect ? lat_addr : '0;
    databus      = chipselect ? lat_data : '0;
    ack0         = chipselect & ~lat_id;
    ack1         = chipselect & lat_id;
    busy         = (state != IDLE);
    state_dbg    = state;
  end

endmodule

// File: tb/tb_graphics_bus_arbiter.sv
// Directed bench for graphics_bus_arbiter: single write, round-robin alternation,
// reset discard, counter saturation, plus frame-lock steps when GFX_ARB_FRAME_LOCK_EN is defined.
module tb_graphics_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, vblank;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, chipselect, busy;
  logic [3:0]  data_address;
  logic [15:0] databus, wr_count;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  graphics_bus_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .vblank(vblank), .chipselect(chipselect), .data_address(data_address),
    .databus(databus), .busy(busy), .wr_count(wr_count), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cs"},   {31'd0, chipselect}, 32'd0);
    check({tag, "_addr"}, {28'd0, data_address}, 32'd0);
    check({tag, "_data"}, {16'd0, databus}, 32'd0);
    check({tag, "_acks"}, {30'd0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; vblank = 1'b1;
    addr0 = 4'h0; addr1 = 4'h0; data0 = 16'h0; data1 = 16'h0;
    tick(); tick();
    rst = 1'b0;
    check_idle_bus("reset");
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", {16'd0, wr_count}, 32'd0);

    // Single ungated write strobes one cycle after it is sampled in IDLE.
    req0 = 1'b1; addr0 = 4'h3; data0 = 16'hABCD;
    tick();
    check("w1_cs", {31'd0, chipselect}, 32'd1);
    check("w1_addr", {28'd0, data_address}, 32'h3);
    check("w1_data", {16'd0, databus}, 32'hABCD);
    check("w1_acks", {30'd0, ack1, ack0}, 32'b01);
    check("w1_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    tick();
    check_idle_bus("w1_gap");
    check("w1_count", {16'd0, wr_count}, 32'd1);
    check("w1_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    check("w1_idle_busy", {31'd0, busy}, 32'd0);

    // Both requesters held high from reset: grants alternate 0,1,0,1 every third cycle.
    rst = 1'b1;
    req0 = 1'b1; addr0 = 4'h5; data0 = 16'h1111;
    req1 = 1'b1; addr1 = 4'hA; data1 = 16'h2222;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_cs", {31'd0, chipselect}, 32'd1);
      check("rr_acks", {30'd0, ack1, ack0}, (k % 2 == 0) ? 32'b01 : 32'b10);
      check("rr_addr", {28'd0, data_address}, (k % 2 == 0) ? 32'h5 : 32'hA);
      check("rr_data", {16'd0, databus}, (k % 2 == 0) ? 32'h1111 : 32'h2222);
      tick();
      check("rr_gap_cs", {31'd0, chipselect}, 32'd0);
      tick();
      check("rr_idle_cs", {31'd0, chipselect}, 32'd0);
      check("rr_idle_busy", {31'd0, busy}, 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_count", {16'd0, wr_count}, 32'd4);

    // Single requester 1 wins even though it was granted last.
    req1 = 1'b1; addr1 = 4'h7; data1 = 16'h7777;
    tick();
    check("solo1_acks", {30'd0, ack1, ack0}, 32'b10);
    check("solo1_addr", {28'd0, data_address}, 32'h7);
    req1 = 1'b0;
    tick(); tick();

    // Reset at the edge that would latch req1 discards it and restores the tie pointer.
    rst = 1'b1; req1 = 1'b1;
    tick();
    rst = 1'b0; req1 = 1'b0;
    check_idle_bus("rst_discard");
    check("rst_discard_busy", {31'd0, busy}, 32'd0);
    check("rst_discard_count", {16'd0, wr_count}, 32'd0);
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'h1; data0 = 16'h00F0;
    tick();
    check("rst_tie_acks", {30'd0, ack1, ack0}, 32'b01);
    check("rst_tie_data", {16'd0, databus}, 32'h00F0);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

`ifdef GFX_ARB_FRAME_LOCK_EN
    // Gate closed: request waits in WAIT_VB until vblank is sampled high.
    vblank = 1'b0; req1 = 1'b1; addr1 = 4'h9; data1 = 16'h9999;
    tick();
    for (int c = 0; c < 8; c++) begin
      check("fl_wait_cs", {31'd0, chipselect}, 32'd0);
      check("fl_wait_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    vblank = 1'b1;
    tick();
    check("fl_strobe_acks", {30'd0, ack1, ack0}, 32'b10);
    check("fl_strobe_addr", {28'd0, data_address}, 32'h9);
    req1 = 1'b0;
    tick(); tick();
    // Reset while a request is parked in WAIT_VB drops it without an ack.
    vblank = 1'b0; req0 = 1'b1;
    tick();
    check("fl_parked_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    check_idle_bus("fl_rst");
    check("fl_rst_busy", {31'd0, busy}, 32'd0);
    vblank = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick();
    check("fl_rst_tie_acks", {30'd0, ack1, ack0}, 32'b01);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
`endif

    // Saturation: preload the counter, then three more writes must hold it at FFFF.
    force dut.wr_count = 16'hFFFE;
    tick();
    release dut.wr_count;
    tick();
    check("sat_preload", {16'd0, wr_count}, 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      req0 = 1'b1; addr0 = 4'h2; data0 = 16'h0BAD;
      tick();
      check("sat_cs", {31'd0, chipselect}, 32'd1);
      req0 = 1'b0;
      tick();
      check("sat_count", {16'd0, wr_count}, 32'hFFFF);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
